// File: rtl/rc4p_pkg.sv
// rc4p_pkg: shared definitions for the parametrised RC4 keystream engine.
// Holds the FSM state encoding, the default geometry and the drop count
// used by the optional RC4-drop mode (macro RC4P_DROP_EN).
package rc4p_pkg;

  // Engine sequencing states
  typedef enum logic [2:0] {
    IDLE,
    KLOAD,
    INIT,
    KSA,
    PA,
    PB,
    DONE
  } state_t;

  // Default geometry: 4-bit words, 16-entry S-box, 4-word key, 16-word buffer
  localparam int DEF_W         = 4;
  localparam int DEF_KEY_LEN   = 4;
  localparam int DEF_OUT_DEPTH = 16;

  // Number of discarded PRGA words in drop mode (one full S-box pass)
  localparam int DROP_COUNT    = 1 << DEF_W;

endpackage

// File: rtl/rc4p_sbox.sv
// rc4p_sbox: 2^W x W flop register file holding the RC4 permutation.
// Three combinational read ports, a single-cycle dual-write swap port,
// a synchronous init-write port and an asynchronous active-low clear.
module rc4p_sbox
  import rc4p_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init_en,
  input  logic [W-1:0] init_idx,
  input  logic [W-1:0] init_data,
  input  logic         swap_en,
  input  logic [W-1:0] wa_idx,
  input  logic [W-1:0] wa_data,
  input  logic [W-1:0] wb_idx,
  input  logic [W-1:0] wb_data,
  input  logic [W-1:0] rd_a_idx,
  output logic [W-1:0] rd_a_data,
  input  logic [W-1:0] rd_b_idx,
  output logic [W-1:0] rd_b_data,
  input  logic [W-1:0] rd_c_idx,
  output logic [W-1:0] rd_c_data
);

  localparam int N = 1 << W;

  logic [W-1:0] s_q [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_entry
      logic [W-1:0] entry_reg;

      // Per-entry storage: init write wins, otherwise either half of a swap.
      // When both swap indices match this entry the two data words are equal.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          entry_reg <= '0;
        end else if (init_en && (init_idx == W'(gi))) begin
          entry_reg <= init_data;
        end else if (swap_en && (wa_idx == W'(gi))) begin
          entry_reg <= wa_data;
        end else if (swap_en && (wb_idx == W'(gi))) begin
          entry_reg <= wb_data;
        end
      end

      assign s_q[gi] = entry_reg;
    end
  endgenerate

  assign rd_a_data = s_q[rd_a_idx];
  assign rd_b_data = s_q[rd_b_idx];
  assign rd_c_data = s_q[rd_c_idx];

endmodule

// File: rtl/rc4p_keystream_engine.sv
// rc4p_keystream_engine: loads a KEY_LEN-word key over valid/ready, runs
// RC4 INIT/KSA/PRGA on a 2^W-entry S-box and fills an OUT_DEPTH-word
// keystream buffer that is read by address with one cycle of latency.
// Optional build macro RC4P_DROP_EN discards the first 2^W PRGA words.
module rc4p_keystream_engine
  import rc4p_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int KEY_LEN   = DEF_KEY_LEN,
  parameter int OUT_DEPTH = DEF_OUT_DEPTH,
  parameter int ADDR_W    = $clog2(OUT_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              key_valid,
  input  logic [W-1:0]      key_data,
  output logic              key_ready,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] add_to_read,
  output logic [W-1:0]      out
);

  localparam int                KCW      = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [KCW-1:0]    KEY_LAST = KCW'(KEY_LEN - 1);
  localparam logic [ADDR_W-1:0] BUF_LAST = ADDR_W'(OUT_DEPTH - 1);

  state_t            state_reg;
  logic [W-1:0]      i_reg;
  logic [W-1:0]      j_reg;
  logic [KCW-1:0]    cnt_reg;   // key word being loaded
  logic [KCW-1:0]    kidx_reg;  // i mod KEY_LEN during KSA
  logic [ADDR_W-1:0] n_reg;     // next buffer slot to write
  logic              drop_phase;

  logic [W-1:0] key_q  [KEY_LEN];
  logic [W-1:0] kbuf_q [OUT_DEPTH];

  logic         key_we;
  logic         kbuf_we;
  logic [W-1:0] key_term;
  logic [W-1:0] s_a_idx;
  logic [W-1:0] s_a;
  logic [W-1:0] s_b_idx;
  logic [W-1:0] s_b;
  logic [W-1:0] s_c_idx;
  logic [W-1:0] s_c;
  logic [W-1:0] j_new;

  // key_ready mirrors the KLOAD state, so this is the accepted handshake
  assign key_we  = key_valid && key_ready;
  assign kbuf_we = (state_reg == PB) && !drop_phase;

  // Read port A: S[i] (KSA, PB) or S[i+1] (PA)
  assign s_a_idx  = (state_reg == PA) ? (i_reg + 1'b1) : i_reg;
  // Key contributes to j only during KSA
  assign key_term = (state_reg == KSA) ? key_q[kidx_reg] : '0;
  assign j_new    = j_reg + s_a + key_term;
  // Read port B: S[j'] for the swap states, S[j] when forming the output index
  assign s_b_idx  = (state_reg == PB) ? j_reg : j_new;
  // Read port C: keystream word S[S[i]+S[j]]
  assign s_c_idx  = s_a + s_b;

  rc4p_sbox #(
    .W(W)
  ) u_sbox (
    .clk       (clk),
    .reset     (reset),
    .init_en   (state_reg == INIT),
    .init_idx  (i_reg),
    .init_data (i_reg),
    .swap_en   ((state_reg == KSA) || (state_reg == PA)),
    .wa_idx    (s_a_idx),
    .wa_data   (s_b),
    .wb_idx    (s_b_idx),
    .wb_data   (s_a),
    .rd_a_idx  (s_a_idx),
    .rd_a_data (s_a),
    .rd_b_idx  (s_b_idx),
    .rd_b_data (s_b),
    .rd_c_idx  (s_c_idx),
    .rd_c_data (s_c)
  );

  generate
    for (genvar gi = 0; gi < KEY_LEN; gi++) begin : g_key
      logic [W-1:0] key_word_reg;

      // Capture key word gi when the load counter points at it
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          key_word_reg <= '0;
        end else if (key_we && (cnt_reg == KCW'(gi))) begin
          key_word_reg <= key_data;
        end
      end

      assign key_q[gi] = key_word_reg;
    end

    for (genvar gi = 0; gi < OUT_DEPTH; gi++) begin : g_kbuf
      logic [W-1:0] word_reg;

      // Keystream slot gi, written in PB when n points at it; kept across runs
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          word_reg <= '0;
        end else if (kbuf_we && (n_reg == ADDR_W'(gi))) begin
          word_reg <= s_c;
        end
      end

      assign kbuf_q[gi] = word_reg;
    end
  endgenerate

  // Registered buffer read port, usable in every state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out <= '0;
    end else begin
      out <= kbuf_q[add_to_read];
    end
  end

`ifdef RC4P_DROP_EN
  logic [W-1:0] drop_cnt_reg;
  logic         drop_reg;

  // Discard one full S-box pass of PRGA words before the buffer fills
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_reg     <= 1'b0;
      drop_cnt_reg <= '0;
    end else if ((state_reg == KSA) && (i_reg == '1)) begin
      drop_reg     <= 1'b1;
      drop_cnt_reg <= '0;
    end else if ((state_reg == PB) && drop_reg) begin
      drop_cnt_reg <= drop_cnt_reg + 1'b1;
      if (drop_cnt_reg == '1) begin
        drop_reg <= 1'b0;
      end
    end
  end

  assign drop_phase = drop_reg;
`else
  assign drop_phase = 1'b0;
`endif

  // Sequencer with registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
      cnt_reg   <= '0;
      kidx_reg  <= '0;
      n_reg     <= '0;
      key_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // busy rises with an accepted start; done lags entry to DONE by one cycle
      // and drops on the edge that accepts the next start
      busy <= !((state_reg == IDLE) || (state_reg == DONE)) || start;
      done <= (state_reg == DONE) && !start;

      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg <= KLOAD;
            cnt_reg   <= '0;
            key_ready <= 1'b1;
          end
        end

        KLOAD: begin
          if (key_we) begin
            if (cnt_reg == KEY_LAST) begin
              state_reg <= INIT;
              cnt_reg   <= '0;
              key_ready <= 1'b0;
              i_reg     <= '0;
              j_reg     <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end

        INIT: begin
          i_reg <= i_reg + 1'b1;
          if (i_reg == '1) begin
            state_reg <= KSA;
            i_reg     <= '0;
            j_reg     <= '0;
            kidx_reg  <= '0;
          end
        end

        KSA: begin
          i_reg    <= i_reg + 1'b1;
          j_reg    <= j_new;
          kidx_reg <= (kidx_reg == KEY_LAST) ? '0 : (kidx_reg + 1'b1);
          if (i_reg == '1) begin
            state_reg <= PA;
            i_reg     <= '0;
            j_reg     <= '0;
            n_reg     <= '0;
          end
        end

        PA: begin
          i_reg     <= s_a_idx;
          j_reg     <= j_new;
          state_reg <= PB;
        end

        PB: begin
          state_reg <= PA;
          if (!drop_phase) begin
            n_reg <= n_reg + 1'b1;
            if (n_reg == BUF_LAST) begin
              state_reg <= DONE;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc4p_keystream_engine.sv
// tb_rc4p_keystream_engine: randomized self-checking bench for the RC4
// keystream engine (default geometry plus a W=5/KEY_LEN=7/OUT_DEPTH=32 copy).
// Honours RC4P_DROP_EN when the design is built with it.
module tb_rc4p_keystream_engine;

`ifdef RC4P_DROP_EN
  localparam int DROP_EN = 1;
`else
  localparam int DROP_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       start0 = 1'b0;
  logic       kv0 = 1'b0;
  logic [3:0] kd0 = '0;
  logic       kr0;
  logic       busy0;
  logic       done0;
  logic [3:0] addr0 = '0;
  logic [3:0] out0;

  logic       start1 = 1'b0;
  logic       kv1 = 1'b0;
  logic [4:0] kd1 = '0;
  logic       kr1;
  logic       busy1;
  logic       done1;
  logic [4:0] addr1 = '0;
  logic [4:0] out1;

  int n_tests = 0;
  int n_fail  = 0;
  int key_m [64];
  int exp_m [64];

  rc4p_keystream_engine dut0 (
    .clk         (clk),
    .reset       (reset),
    .start       (start0),
    .key_valid   (kv0),
    .key_data    (kd0),
    .key_ready   (kr0),
    .busy        (busy0),
    .done        (done0),
    .add_to_read (addr0),
    .out         (out0)
  );

  rc4p_keystream_engine #(
    .W         (5),
    .KEY_LEN   (7),
    .OUT_DEPTH (32)
  ) dut1 (
    .clk         (clk),
    .reset       (reset),
    .start       (start1),
    .key_valid   (kv1),
    .key_data    (kd1),
    .key_ready   (kr1),
    .busy        (busy1),
    .done        (done1),
    .add_to_read (addr1),
    .out         (out1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic int get_rdy(input bit sel);
    return sel ? int'(kr1) : int'(kr0);
  endfunction
  function automatic int get_busy(input bit sel);
    return sel ? int'(busy1) : int'(busy0);
  endfunction
  function automatic int get_done(input bit sel);
    return sel ? int'(done1) : int'(done0);
  endfunction
  function automatic int get_out(input bit sel);
    return sel ? int'(out1) : int'(out0);
  endfunction

  // Textbook RC4 on an n-entry permutation; words after ndrop go to exp_m
  task automatic ref_model(input int w, input int klen, input int nout, input int ndrop);
    int s [32];
    int n;
    int i;
    int j;
    int t;
    n = 1 << w;
    for (int k = 0; k < n; k++) s[k] = k;
    j = 0;
    for (int k = 0; k < n; k++) begin
      j = (j + s[k] + key_m[k % klen]) % n;
      t = s[k]; s[k] = s[j]; s[j] = t;
    end
    i = 0;
    j = 0;
    for (int m = 0; m < ndrop + nout; m++) begin
      i = (i + 1) % n;
      j = (j + s[i]) % n;
      t = s[i]; s[i] = s[j]; s[j] = t;
      if (m >= ndrop) exp_m[m - ndrop] = s[(s[i] + s[j]) % n];
    end
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Full run: start, key load (optionally gapped), wait for done, check timing
  task automatic run(input bit sel, input int klen, input bit gaps, input bit poke, input int nout);
    int  idx = 0;
    int  hs = 0;
    int  cyc = 0;
    int  rdy_cnt = 0;
    int  lat = 0;
    int  w;
    int  exp_lat;
    bit  tgl = 1'b0;
    bit  v;
    w = sel ? 5 : 4;
    exp_lat = 2 * (1 << w) + 2 * nout + 1 + DROP_EN * 2 * (1 << w);
    pulse_start(sel);
    while (idx < klen && cyc < 200) begin
      v = gaps ? !tgl : 1'b1;
      tgl = !tgl;
      if (sel) begin kv1 = v; kd1 = 5'(key_m[idx]); end
      else begin kv0 = v; kd0 = 4'(key_m[idx]); end
      if (get_rdy(sel) != 0) rdy_cnt++;
      if (v && get_rdy(sel) != 0) begin idx++; hs++; end
      @(negedge clk);
      cyc++;
    end
    kv0 = 1'b0;
    kv1 = 1'b0;
    check($sformatf("handshakes_dut%0d", sel), hs, klen);
    check($sformatf("key_ready_in_kload_dut%0d", sel), rdy_cnt, cyc);
    while (get_done(sel) == 0 && lat < 400) begin
      if (lat == 8) check($sformatf("busy_mid_run_dut%0d", sel), get_busy(sel), 1);
      if (poke && lat == 20) begin
        if (sel) start1 = 1'b1; else start0 = 1'b1;
      end else begin
        start0 = 1'b0;
        start1 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start0 = 1'b0;
    start1 = 1'b0;
    check($sformatf("done_latency_dut%0d", sel), lat, exp_lat);
    check($sformatf("busy_at_done_dut%0d", sel), get_busy(sel), 0);
    $display("[TB] run dut%0d gaps=%0d poke=%0d handshakes=%0d latency=%0d", sel, gaps, poke, hs, lat);
  endtask

  task automatic read_word(input bit sel, input int a, output int v);
    if (sel) addr1 = 5'(a); else addr0 = 4'(a);
    @(negedge clk);
    v = get_out(sel);
  endtask

  task automatic check_buf(input bit sel, input int nout, input string tag);
    int v;
    for (int a = 0; a < nout; a++) begin
      read_word(sel, a, v);
      check($sformatf("%s[%0d]", tag, a), v, exp_m[a]);
    end
  endtask

  initial begin
    int v;

    // Reset state, held and in the first cycle after release
    #12;
    check("rst_key_ready", int'(kr0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_out", int'(out0), 0);
    check("rst_done_dut1", int'(done1), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_key_ready", int'(kr0), 0);
    check("post_rst_busy", int'(busy0), 0);
    check("post_rst_done", int'(done0), 0);
    check("post_rst_out", int'(out0), 0);

    // All-zero key, back-to-back handshakes
    for (int k = 0; k < 4; k++) key_m[k] = 0;
    ref_model(4, 4, 16, DROP_EN * 16);
    run(1'b0, 4, 1'b0, 1'b0, 16);
    check_buf(1'b0, 16, "zero_key");
`ifndef RC4P_DROP_EN
    read_word(1'b0, 0, v); check("zero_key_lit0", v, 8);
    read_word(1'b0, 1, v); check("zero_key_lit1", v, 15);
    read_word(1'b0, 2, v); check("zero_key_lit2", v, 6);
`endif

    // Same key with key_valid toggling 1,0,1,0 during the load
    run(1'b0, 4, 1'b1, 1'b0, 16);
    check_buf(1'b0, 16, "zero_key_gapped");

    // Random keys, gapped load
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) key_m[k] = $urandom_range(0, 15);
      ref_model(4, 4, 16, DROP_EN * 16);
      run(1'b0, 4, 1'b1, 1'b0, 16);
      check_buf(1'b0, 16, $sformatf("rand_key%0d", r));
    end

    // start pulsed during KSA is ignored; then key_valid pulsed in DONE
    for (int k = 0; k < 4; k++) key_m[k] = $urandom_range(0, 15);
    ref_model(4, 4, 16, DROP_EN * 16);
    run(1'b0, 4, 1'b0, 1'b1, 16);
    check_buf(1'b0, 16, "ksa_poke");
    for (int c = 0; c < 4; c++) begin
      kv0 = 1'b1;
      kd0 = 4'($urandom_range(0, 15));
      @(negedge clk);
      check("done_poke_key_ready", int'(kr0), 0);
      check("done_poke_done", int'(done0), 1);
      check("done_poke_busy", int'(busy0), 0);
    end
    kv0 = 1'b0;
    check_buf(1'b0, 16, "after_done_poke");

    // Reset mid-PRGA, then rerun with the zero key
    for (int k = 0; k < 4; k++) key_m[k] = $urandom_range(1, 15);
    pulse_start(1'b0);
    for (int k = 0; k < 4; k++) begin
      kv0 = 1'b1;
      kd0 = 4'(key_m[k]);
      @(negedge clk);
    end
    kv0 = 1'b0;
    repeat (40) @(negedge clk);
    check("prga_busy_before_reset", int'(busy0), 1);
    #2 reset = 1'b0;
    #1;
    check("midrun_rst_key_ready", int'(kr0), 0);
    check("midrun_rst_busy", int'(busy0), 0);
    check("midrun_rst_done", int'(done0), 0);
    check("midrun_rst_out", int'(out0), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midrun_idle_busy", int'(busy0), 0);
    check("midrun_idle_key_ready", int'(kr0), 0);
    read_word(1'b0, 3, v);
    check("midrun_buf_cleared", v, 0);
    for (int k = 0; k < 4; k++) key_m[k] = 0;
    ref_model(4, 4, 16, DROP_EN * 16);
    run(1'b0, 4, 1'b0, 1'b0, 16);
    check_buf(1'b0, 16, "rerun_zero_key");

    // Wider geometry with a random 7-word key
    for (int k = 0; k < 7; k++) key_m[k] = $urandom_range(0, 31);
    ref_model(5, 7, 32, DROP_EN * 32);
    run(1'b1, 7, 1'b0, 1'b0, 32);
    check_buf(1'b1, 32, "w5_key");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rc4p_keystream_engine.md
Name: rc4p_keystream_engine

Overview:
- Parametrised successor to the fixed 4-bit RC4 keystream path fed by the SPECK hash output.
- Accepts a KEY_LEN-word key over a valid/ready stream (hash side pushes nibbles), replacing the divided-clock key registers.
- Runs INIT, KSA and PRGA on a 2^W-entry S-box and fills an OUT_DEPTH-word keystream buffer, read by address.
- All logic is on one clock; there is no derived clock.

Parameters:
- W, 4, word width; the S-box has 2^W entries of W bits.
- KEY_LEN, 4, key length in words (1..2^W).
- OUT_DEPTH, 16, keystream words generated per run; must be a power of 2.
- ADDR_W, $clog2(OUT_DEPTH), read address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- key_valid  in  1  key word present.
- key_data  in  W  key word; word 0 arrives first.
- key_ready  out  1  engine accepts a key word this cycle.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE, held until the next accepted start.
- add_to_read  in  ADDR_W  keystream buffer read address.
- out  out  W  buffer[add_to_read], registered (1-cycle read latency).

Behaviour:
- Reset (any time, mid-run included): FSM goes to IDLE; i, j and the key-word counter clear to 0; S-box, key registers and buffer clear to 0. All outputs are 0 during reset and in the first cycle after it.
- IDLE: start=1 -> KLOAD. The start edge itself is not a key cycle.
- KLOAD:
  - key_ready=1.
  - A word is taken on each cycle with key_valid & key_ready and written to K[cnt].
  - After word KEY_LEN-1 is taken -> INIT next cycle.
  - Gaps in key_valid only stall; no timeout.
- INIT:
  - One entry per cycle: S[i]=i for i=0..2^W-1.
  - Lasts 2^W cycles; i and j clear on exit.
- KSA:
  - One iteration per cycle, i=0..2^W-1.
  - j' = (j + S[i] + K[i mod KEY_LEN]) mod 2^W; swap S[i] and S[j'] in the same edge.
  - i==j' leaves S unchanged.
  - Lasts 2^W cycles; i and j clear on exit.
- PRGA: two cycles per output word.
  - PA: i'=i+1, j'=j+S[i'], swap S[i'] and S[j'].
  - PB: buf[n] = S[(S[i]+S[j]) mod 2^W] using the post-swap S; n++.
  - After n = OUT_DEPTH-1 is written -> DONE.
- DONE: done=1, busy=0. start=1 -> KLOAD, which clears done; the buffer is retained until overwritten.
- Timing: done rises 2^W + 2^W + 2*OUT_DEPTH + 1 cycles after the edge that accepts the last key word. With defaults this is 65 cycles.
- start while busy is ignored.
- key_valid outside KLOAD is ignored; key_ready stays 0.
- All index arithmetic wraps mod 2^W with no carry out.
- The buffer is readable in every state. Reading during PRGA returns the old contents for addresses not yet written.

Optional Feature:
- Macro: RC4P_DROP_EN.
- When defined, PRGA first generates and discards 2^W words (RC4-drop) before writing buf[0]. This adds 2*2^W cycles to done latency: 97 cycles with defaults.
- When undefined, the first generated word is written to buf[0].

Decomposition:
- Package rc4p_pkg holds:
  - the FSM state enum (IDLE, KLOAD, INIT, KSA, PA, PB, DONE);
  - default W, KEY_LEN and OUT_DEPTH constants;
  - the DROP_COUNT constant (2^W).
- Sub-module rc4p_sbox:
  - 2^W x W flop register file;
  - two combinational read ports plus a third for the output index;
  - one-cycle dual-write swap port;
  - synchronous init-write port;
  - asynchronous active-low clear.
- Key registers, buffer and FSM stay in the top block.

Test Plan:
- Key 0,0,0,0, defaults, macro off -> done 65 cycles after the last key handshake; buf[0..2] = 8, 15, 6.
- Same key with RC4P_DROP_EN defined -> done at 97 cycles; buffer matches reference model words 16..31 of the undropped stream.
- key_valid toggled 1,0,1,0,... during KLOAD -> exactly 4 handshakes; final buffer identical to the back-to-back case; done delayed by the stall count only.
- start pulsed during KSA, and key_valid pulsed in DONE -> no state change, key_ready stays 0, buffer unaffected.
- reset driven low mid-PRGA -> outputs 0 immediately, FSM returns to IDLE; a rerun with key 0,0,0,0 reproduces 8, 15, 6.
- W=5, KEY_LEN=7, OUT_DEPTH=32 with a random key -> all 32 words match the reference model; done at 32+32+64+1 = 129 cycles.
